// File: rtl/npc_pkg.sv
// Shared npc core types and widths.
// Used by the fetch unit, its FIFOs and the idu input.
package npc_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/npc_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Head data reads as zero while empty.
module npc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst)
      mem[wr_ptr] <= wdata;
  end

  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: credit-limited icache requests, fetch queue.
// Optional same-cycle response bypass: IFU_FQ_BYPASS_EN.
module ifu_fetch_queue
  import npc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = npc_pkg::ADDR_WIDTH,
  parameter int                    INST_WIDTH = npc_pkg::INST_WIDTH,
  parameter int                    FQ_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = npc_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  input  logic                  rsp_valid_i,
  input  logic [INST_WIDTH-1:0] rsp_instr_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [INST_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  localparam int CW  = $clog2(FQ_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int EW  = $bits(fetch_entry_t);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pc_head;
  logic [CW-1:0]         drop;
  logic [CW-1:0]         pc_count;
  logic [CW-1:0]         occupancy;
  logic [CW-1:0]         outstanding;
  logic [CW:0]           credit_used;
  logic                  req_fire;
  logic                  rsp_drop;
  logic                  rsp_ok;
  logic                  q_push;
  logic                  q_pop;
  logic                  byp;
  fetch_entry_t          rsp_entry;
  fetch_entry_t          q_head;

  // Stale requests live only in drop; live ones in the PC FIFO.
  assign outstanding = pc_count + drop;
  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};

  assign req_valid_o = !rst && !redirect_valid_i &&
                       (credit_used < CW1'(FQ_DEPTH));
  assign req_addr_o  = fetch_pc;
  assign req_fire    = req_valid_o && req_ready_i;

  assign rsp_drop  = drop != '0;
  assign rsp_ok    = rsp_valid_i && !rsp_drop && !redirect_valid_i;
  assign rsp_entry = '{pc: pc_head, instr: rsp_instr_i};

`ifdef IFU_FQ_BYPASS_EN
  assign byp = rsp_ok && (occupancy == '0);
`else
  assign byp = 1'b0;
`endif

  assign instr_valid_o     = (occupancy != '0) || byp;
  assign {pc_o, instr_o}   = byp ? rsp_entry : q_head;
  assign q_pop             = (occupancy != '0) && instr_ready_i;
  assign q_push            = rsp_ok && !(byp && instr_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (redirect_valid_i) begin
      fetch_pc <= redirect_pc_i & ~ADDR_WIDTH'(3);
      drop     <= outstanding - CW'(rsp_valid_i);
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      if (rsp_valid_i && rsp_drop)
        drop <= drop - CW'(1);
    end
  end

  npc_sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (FQ_DEPTH)
  ) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (rsp_valid_i && !rsp_drop),
    .flush (redirect_valid_i),
    .rdata (pc_head),
    .count (pc_count)
  );

  npc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (rsp_entry),
    .pop   (q_pop),
    .flush (redirect_valid_i),
    .rdata (q_head),
    .count (occupancy)
  );

endmodule
